// File: rtl/gt_tx_lane_sequencer_if.sv
// Per-lane control/status bundle between the SFP+ cage/PHY glue and the TX lane sequencer.
interface gt_tx_lane_sequencer_if #(
    parameter int LANES = 2
);
    logic [LANES-1:0]   lane_enable;
    logic               tx_reset_done;
    logic [LANES-1:0]   sfp_npres;
    logic [LANES-1:0]   sfp_tx_disable;
    logic [LANES-1:0]   phy_tx_rst;
    logic [LANES-1:0]   force_idle;
    logic [LANES-1:0]   lane_up;
    logic [LANES*8-1:0] fault_count;

    modport master (
        output lane_enable, tx_reset_done, sfp_npres,
        input  sfp_tx_disable, phy_tx_rst, force_idle, lane_up, fault_count
    );

    modport slave (
        input  lane_enable, tx_reset_done, sfp_npres,
        output sfp_tx_disable, phy_tx_rst, force_idle, lane_up, fault_count
    );
endinterface

// File: rtl/gt_tx_lane_sequencer.sv
// Per-lane SFP+ TX bring-up/teardown sequencer: laser enable, PHY TX reset and idle
// forcing are released in order, and faults tear the lane down through a timed hold-off.
module gt_tx_lane_sequencer #(
    parameter int LANES          = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int IDLE_CYCLES    = 1024,
    parameter int HOLDOFF_CYCLES = 65536
) (
    input  logic                  gt_txusrclk,
    input  logic                  gt_tx_reset,
    gt_tx_lane_sequencer_if.slave bus
);

    localparam int CNT_MAX = (IDLE_CYCLES > HOLDOFF_CYCLES) ? IDLE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] IDLE_LOAD    = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE = 3'd1;
    localparam logic [2:0] ST_IDLE_FILL = 3'd2;
    localparam logic [2:0] ST_ACTIVE    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    // tx_reset_done is common to the quad, so a single synchronizer feeds every lane.
    logic [SYNC_STAGES-1:0] done_sync_reg;
    logic                   done_s;

    always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            done_sync_reg <= '0;
        end else begin
            done_sync_reg <= {done_sync_reg[SYNC_STAGES-2:0], bus.tx_reset_done};
        end
    end

    assign done_s = done_sync_reg[SYNC_STAGES-1];

    logic [LANES-1:0]   tx_disable_vec;
    logic [LANES-1:0]   phy_rst_vec;
    logic [LANES-1:0]   idle_vec;
    logic [LANES-1:0]   up_vec;
    logic [LANES*8-1:0] fault_vec;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SYNC_STAGES-1:0] en_sync_reg;
            logic [SYNC_STAGES-1:0] npres_sync_reg;
            logic                   en_s;
            logic                   npres_s;
            logic                   fault_hit;
            logic [2:0]             state_reg;
            logic [2:0]             state_next;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;
            logic [7:0]             fault_reg;
            logic [7:0]             fault_next;

            // Synchronizers come out of reset in the safe state: disabled, module absent.
            always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
                if (gt_tx_reset) begin
                    en_sync_reg    <= '0;
                    npres_sync_reg <= '1;
                end else begin
                    en_sync_reg    <= {en_sync_reg[SYNC_STAGES-2:0], bus.lane_enable[gi]};
                    npres_sync_reg <= {npres_sync_reg[SYNC_STAGES-2:0], bus.sfp_npres[gi]};
                end
            end

            assign en_s      = en_sync_reg[SYNC_STAGES-1];
            assign npres_s   = npres_sync_reg[SYNC_STAGES-1];
            assign fault_hit = npres_s | ~done_s;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                fault_next = fault_reg;
                if (!en_s) begin
                    state_next = ST_OFF;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        ST_OFF: begin
                            if (!npres_s) state_next = ST_WAIT_DONE;
                        end
                        ST_WAIT_DONE: begin
                            if (npres_s) begin
                                state_next = ST_OFF;
                            end else if (done_s) begin
                                state_next = ST_IDLE_FILL;
                                cnt_next   = IDLE_LOAD;
                            end
                        end
                        ST_IDLE_FILL: begin
                            if (fault_hit) begin
                                state_next = ST_HOLDOFF;
                                cnt_next   = HOLDOFF_LOAD;
                            end else if (cnt_reg == '0) begin
                                state_next = ST_ACTIVE;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        ST_ACTIVE: begin
                            if (fault_hit) begin
                                state_next = ST_HOLDOFF;
                                cnt_next   = HOLDOFF_LOAD;
                                if (fault_reg != 8'hFF) fault_next = fault_reg + 8'd1;
                            end
                        end
                        ST_HOLDOFF: begin
                            if (cnt_reg == '0) begin
                                state_next = ST_OFF;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        default: begin
                            state_next = ST_OFF;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
                if (gt_tx_reset) begin
                    state_reg <= ST_OFF;
                    cnt_reg   <= '0;
                    fault_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    fault_reg <= fault_next;
                end
            end

            always_comb begin
                tx_disable_vec[gi] = 1'b1;
                phy_rst_vec[gi]    = 1'b1;
                idle_vec[gi]       = 1'b1;
                up_vec[gi]         = 1'b0;
                case (state_reg)
                    ST_WAIT_DONE: begin
                        tx_disable_vec[gi] = 1'b0;
                    end
                    ST_IDLE_FILL: begin
                        tx_disable_vec[gi] = 1'b0;
                        phy_rst_vec[gi]    = 1'b0;
                    end
                    ST_ACTIVE: begin
                        tx_disable_vec[gi] = 1'b0;
                        phy_rst_vec[gi]    = 1'b0;
                        idle_vec[gi]       = 1'b0;
                        up_vec[gi]         = 1'b1;
                    end
                    default: begin
                        tx_disable_vec[gi] = 1'b1;
                    end
                endcase
            end

            assign fault_vec[8*gi +: 8] = fault_reg;
        end
    endgenerate

    assign bus.sfp_tx_disable = tx_disable_vec;
    assign bus.phy_tx_rst     = phy_rst_vec;
    assign bus.force_idle     = idle_vec;
    assign bus.lane_up        = up_vec;
    assign bus.fault_count    = fault_vec;

endmodule

// File: tb/tb_gt_tx_lane_sequencer.sv
// Randomized and directed bench for gt_tx_lane_sequencer against a phase/age lane model.
module tb_gt_tx_lane_sequencer;
    localparam int LANES = 2;
    localparam int SYNC  = 2;
    localparam int IDLE  = 8;
    localparam int HOLD  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gt_tx_lane_sequencer_if #(.LANES(LANES)) bus ();

    gt_tx_lane_sequencer #(
        .LANES(LANES), .SYNC_STAGES(SYNC), .IDLE_CYCLES(IDLE), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .gt_txusrclk(clk),
        .gt_tx_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef enum int {M_OFF, M_WAIT, M_FILL, M_ACT, M_HOLD} mphase_t;
    mphase_t          ph     [LANES];
    int               age    [LANES];
    int               faults [LANES];
    logic [LANES-1:0] en_q[$];
    logic [LANES-1:0] np_q[$];
    logic             done_q[$];

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            ph[l] = M_OFF; age[l] = 0; faults[l] = 0;
        end
        en_q.delete(); np_q.delete(); done_q.delete();
    endtask

    // Pins reach the lane logic SYNC edges after they are sampled; before that, safe defaults.
    task automatic model_step();
        logic [LANES-1:0] en_s, np_s;
        logic             done_s;
        en_q.push_back(bus.lane_enable);
        np_q.push_back(bus.sfp_npres);
        done_q.push_back(bus.tx_reset_done);
        if (en_q.size() > SYNC) begin
            en_s = en_q.pop_front(); np_s = np_q.pop_front(); done_s = done_q.pop_front();
        end else begin
            en_s = '0; np_s = '1; done_s = 1'b0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (!en_s[l]) begin
                ph[l] = M_OFF; age[l] = 0;
            end else begin
                case (ph[l])
                    M_OFF:  if (!np_s[l]) ph[l] = M_WAIT;
                    M_WAIT: if (np_s[l]) ph[l] = M_OFF;
                            else if (done_s) begin ph[l] = M_FILL; age[l] = 0; end
                    M_FILL: if (np_s[l] || !done_s) begin ph[l] = M_HOLD; age[l] = 0; end
                            else begin age[l]++; if (age[l] == IDLE) ph[l] = M_ACT; end
                    M_ACT:  if (np_s[l] || !done_s) begin
                                ph[l] = M_HOLD; age[l] = 0;
                                if (faults[l] < 255) faults[l]++;
                            end
                    M_HOLD: begin age[l]++; if (age[l] == HOLD) ph[l] = M_OFF; end
                    default: ph[l] = M_OFF;
                endcase
            end
        end
    endtask

    // {sfp_tx_disable, phy_tx_rst, force_idle, lane_up}
    function automatic logic [3:0] exp_ctl(input mphase_t p);
        case (p)
            M_WAIT:  return 4'b0110;
            M_FILL:  return 4'b0010;
            M_ACT:   return 4'b0001;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic compare_model();
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("lane%0d_ctl", l),
                  {28'd0, bus.sfp_tx_disable[l], bus.phy_tx_rst[l], bus.force_idle[l], bus.lane_up[l]},
                  {28'd0, exp_ctl(ph[l])});
            check($sformatf("lane%0d_faults", l), {24'd0, bus.fault_count[8*l +: 8]}, faults[l]);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
            #1;
            compare_model();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_txdis"}, bus.sfp_tx_disable, 2'b11);
        check({tag, "_phyrst"}, bus.phy_tx_rst, 2'b11);
        check({tag, "_idle"}, bus.force_idle, 2'b11);
        check({tag, "_up"}, bus.lane_up, 2'b00);
        check({tag, "_faults"}, bus.fault_count, 16'h0000);
    endtask

    initial begin
        bus.lane_enable   = 2'b00;
        bus.sfp_npres     = 2'b11;
        bus.tx_reset_done = 1'b0;
        model_reset();
        #2;
        check_reset_values("reset");
        run_cycles(2);
        rst = 1'b0;
        $display("txn reset released at %0t", $time);

        // Normal bring-up on lane 0, lane 1 enabled-off with module absent.
        bus.lane_enable = 2'b01; bus.sfp_npres = 2'b10; bus.tx_reset_done = 1'b1;
        run_cycles(2);
        check("bringup_txdis_early", bus.sfp_tx_disable[0], 1'b1);
        run_cycles(1);
        check("bringup_txdis", bus.sfp_tx_disable[0], 1'b0);
        check("bringup_phyrst_hold", bus.phy_tx_rst[0], 1'b1);
        run_cycles(1);
        check("bringup_phyrst", bus.phy_tx_rst[0], 1'b0);
        run_cycles(7);
        check("bringup_up_early", bus.lane_up[0], 1'b0);
        run_cycles(1);
        check("bringup_up", bus.lane_up[0], 1'b1);
        check("bringup_lane1_ctl",
              {bus.sfp_tx_disable[1], bus.phy_tx_rst[1], bus.force_idle[1], bus.lane_up[1]}, 4'b1110);
        $display("txn normal bring-up lane0 up=%0b", bus.lane_up[0]);

        // Module removal on lane 0.
        bus.sfp_npres[0] = 1'b1;
        run_cycles(3);
        check("removal_up", bus.lane_up[0], 1'b0);
        check("removal_txdis", bus.sfp_tx_disable[0], 1'b1);
        check("removal_faults", bus.fault_count[7:0], 8'd1);
        run_cycles(2);
        bus.sfp_npres[0] = 1'b0;
        run_cycles(14);
        check("removal_holdoff_end", bus.sfp_tx_disable[0], 1'b1);
        run_cycles(1);
        check("removal_rewait", bus.sfp_tx_disable[0], 1'b0);
        $display("txn module removal faults=%0d", bus.fault_count[7:0]);

        // TX reset-done lost with both lanes active.
        bus.lane_enable = 2'b11; bus.sfp_npres = 2'b00;
        run_cycles(30);
        check("done_lost_both_up", bus.lane_up, 2'b11);
        bus.tx_reset_done = 1'b0;
        run_cycles(2);
        check("done_lost_still_up", bus.lane_up, 2'b11);
        run_cycles(1);
        check("done_lost_down", bus.lane_up, 2'b00);
        check("done_lost_faults0", bus.fault_count[7:0], 8'd2);
        check("done_lost_faults1", bus.fault_count[15:8], 8'd1);
        bus.tx_reset_done = 1'b1;
        run_cycles(30);
        check("done_back_up", bus.lane_up, 2'b11);
        $display("txn tx done lost faults=%0h", bus.fault_count);

        // Enable abort in the middle of idle fill.
        bus.lane_enable = 2'b10;
        run_cycles(5);
        bus.lane_enable = 2'b11;
        run_cycles(7);
        check("abort_in_fill", {bus.phy_tx_rst[0], bus.force_idle[0]}, 2'b01);
        bus.lane_enable = 2'b10;
        run_cycles(3);
        check("abort_txdis", bus.sfp_tx_disable[0], 1'b1);
        check("abort_faults", bus.fault_count[7:0], 8'd2);
        bus.lane_enable = 2'b11;
        run_cycles(3);
        check("abort_was_off", bus.sfp_tx_disable[0], 1'b0);
        run_cycles(12);
        check("abort_recovered", bus.lane_up, 2'b11);
        $display("txn enable abort lane0 faults=%0d", bus.fault_count[7:0]);

        // Saturate lane 1 fault counter.
        for (int k = 0; k < 300; k++) begin
            bus.sfp_npres[1] = 1'b1;
            run_cycles(19);
            bus.sfp_npres[1] = 1'b0;
            run_cycles(13);
        end
        check("sat_faults1", bus.fault_count[15:8], 8'd255);
        check("sat_faults0", bus.fault_count[7:0], 8'd2);
        check("sat_up", bus.lane_up, 2'b11);
        $display("txn saturation lane1 faults=%0d", bus.fault_count[15:8]);

        // Random pin activity.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.tx_reset_done = ~bus.tx_reset_done;
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 29) == 0)  bus.sfp_npres[l]   = ~bus.sfp_npres[l];
                if ($urandom_range(0, 149) == 0) bus.lane_enable[l] = ~bus.lane_enable[l];
            end
            run_cycles(1);
        end
        $display("txn random run faults=%0h", bus.fault_count);

        // Asynchronous reset during hold-off.
        bus.lane_enable = 2'b11; bus.sfp_npres = 2'b00; bus.tx_reset_done = 1'b1;
        run_cycles(40);
        check("pre_reset_up", bus.lane_up, 2'b11);
        bus.sfp_npres[0] = 1'b1;
        run_cycles(5);
        check("pre_reset_holdoff", bus.sfp_tx_disable[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        run_cycles(2);
        rst = 1'b0;
        bus.sfp_npres[0] = 1'b0;
        run_cycles(20);
        check("post_reset_up", bus.lane_up, 2'b11);
        $display("txn async reset recovery up=%0b", bus.lane_up);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
